// File: rtl/comparator_if.sv
// Compare-unit bus: operands, opcode and sample enable in; registered branch flag out.
interface comparator_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) ();
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd15;
   logic [OPW-1:0]   cmp;
   logic             en;
   logic             br;
   logic             br_valid;

   modport master (output rd1, rd15, cmp, en, input br, br_valid);
   modport slave  (input rd1, rd15, cmp, en, output br, br_valid);
endinterface

// File: rtl/comparator.sv
// Branch-condition unit: compares rd1 against R15 per opcode, registers the
// taken flag with one cycle of latency and flags whether it is fresh.
module comparator #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic        clk,
   input  logic        rst,
   comparator_if.slave bus
);
   localparam logic [OPW-1:0] OP_BLT = OPW'(4'b0100);
   localparam logic [OPW-1:0] OP_BGT = OPW'(4'b0101);
   localparam logic [OPW-1:0] OP_BEQ = OPW'(4'b0110);
   localparam logic [OPW-1:0] OP_BNE = OPW'(4'b0111);

   // Sign-extend by one bit so the signed compare can never overflow.
   logic signed [WIDTH:0] a_ext, b_ext;
   logic                  cond;
   logic                  br_q, vld_q;

   assign a_ext = {bus.rd1[WIDTH-1], bus.rd1};
   assign b_ext = {bus.rd15[WIDTH-1], bus.rd15};

   // Decode the opcode into a branch condition; unknown opcodes never branch.
   always_comb begin
      cond = 1'b0;
      case (bus.cmp)
         OP_BLT:  cond = (a_ext <  b_ext);
         OP_BGT:  cond = (a_ext >  b_ext);
         OP_BEQ:  cond = (bus.rd1 == bus.rd15);
         OP_BNE:  cond = (bus.rd1 != bus.rd15);
         default: cond = 1'b0;
      endcase
   end

   // Capture the condition when enabled; br holds otherwise, valid marks freshness.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_q  <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= bus.en;
         if (bus.en) br_q <= cond;
      end
   end

   assign bus.br       = br_q;
   assign bus.br_valid = vld_q;
endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed scenarios plus a randomized
// sweep against an integer-arithmetic reference model.
module tb_comparator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   exp_br = 1'b0;
   bit   exp_vld = 1'b0;

   comparator_if #(.WIDTH(16), .OPW(4)) bus ();

   comparator #(.WIDTH(16), .OPW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: interpret operands as signed integers, apply opcode rules.
   function automatic bit ref_cond(logic [3:0] op, logic [15:0] a, logic [15:0] b);
      int sa, sb;
      sa = a[15] ? int'(a) - 65536 : int'(a);
      sb = b[15] ? int'(b) - 65536 : int'(b);
      case (op)
         4'd4:    return sa < sb;
         4'd5:    return sa > sb;
         4'd6:    return sa == sb;
         4'd7:    return sa != sb;
         default: return 1'b0;
      endcase
   endfunction

   // Drive one cycle of inputs at negedge, advance the model at the posedge,
   // return #1 after the edge so callers can sample.
   task automatic step(input logic e, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.en = e; bus.cmp = op; bus.rd1 = a; bus.rd15 = b;
      @(posedge clk);
      if (e) begin
         exp_br  = ref_cond(op, a, b);
         exp_vld = 1'b1;
      end else begin
         exp_vld = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      bus.en = 1'b0; bus.cmp = 4'd0; bus.rd1 = 16'h0; bus.rd15 = 16'h0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.br !== 1'b0 || bus.br_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold br=%b valid=%b expected br=0 valid=0", bus.br, bus.br_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.br !== 1'b0 || bus.br_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release br=%b valid=%b expected br=0 valid=0", bus.br, bus.br_valid);
      end
      exp_br = 1'b0; exp_vld = 1'b0;
   endtask

   task automatic test_bgt();
      step(1'b1, 4'b0101, 16'h0000, 16'h0001);
      checks++;
      if (bus.br !== 1'b0 || bus.br_valid !== 1'b1) begin
         failures++;
         $display("FAIL bgt_0_vs_1 br=%b valid=%b expected br=0 valid=1", bus.br, bus.br_valid);
      end
      step(1'b1, 4'b0101, 16'h7FFF, 16'h8000);
      checks++;
      if (bus.br !== 1'b1) begin
         failures++;
         $display("FAIL bgt_max_vs_min br=%b expected 1", bus.br);
      end
   endtask

   task automatic test_blt();
      step(1'b1, 4'b0100, 16'h0001, 16'h0000);
      checks++;
      if (bus.br !== 1'b0) begin
         failures++;
         $display("FAIL blt_1_vs_0 br=%b expected 0", bus.br);
      end
      step(1'b1, 4'b0100, 16'h8000, 16'h0001);
      checks++;
      if (bus.br !== 1'b1) begin
         failures++;
         $display("FAIL blt_signed_8000 br=%b expected 1", bus.br);
      end
      step(1'b1, 4'b0100, 16'h7FFF, 16'h7FFF);
      checks++;
      if (bus.br !== 1'b0) begin
         failures++;
         $display("FAIL blt_equal br=%b expected 0", bus.br);
      end
   endtask

   task automatic test_beq_bne();
      step(1'b1, 4'b0110, 16'h0000, 16'h0000);
      checks++;
      if (bus.br !== 1'b1) begin
         failures++;
         $display("FAIL beq_equal br=%b expected 1", bus.br);
      end
      step(1'b1, 4'b0110, 16'h0000, 16'h0001);
      checks++;
      if (bus.br !== 1'b0) begin
         failures++;
         $display("FAIL beq_diff br=%b expected 0", bus.br);
      end
      step(1'b1, 4'b0111, 16'h0000, 16'h0001);
      checks++;
      if (bus.br !== 1'b1) begin
         failures++;
         $display("FAIL bne_diff br=%b expected 1", bus.br);
      end
      step(1'b1, 4'b0111, 16'hFFFF, 16'hFFFF);
      checks++;
      if (bus.br !== 1'b0) begin
         failures++;
         $display("FAIL bne_equal br=%b expected 0", bus.br);
      end
   endtask

   task automatic test_other_ops_and_hold();
      step(1'b1, 4'b0000, 16'h0000, 16'h0000);
      checks++;
      if (bus.br !== 1'b0) begin
         failures++;
         $display("FAIL op_0000 br=%b expected 0", bus.br);
      end
      step(1'b1, 4'b0111, 16'h1234, 16'h0001);
      step(1'b1, 4'b1111, 16'h8000, 16'h7FFF);
      checks++;
      if (bus.br !== 1'b0) begin
         failures++;
         $display("FAIL op_1111 br=%b expected 0", bus.br);
      end
      // Get br=1, then idle with X operands and opcode: br must hold.
      step(1'b1, 4'b0110, 16'h5555, 16'h5555);
      step(1'b0, 4'bxxxx, 16'hxxxx, 16'hxxxx);
      checks++;
      if (bus.br !== 1'b1 || bus.br_valid !== 1'b0) begin
         failures++;
         $display("FAIL en0_hold br=%b valid=%b expected br=1 valid=0", bus.br, bus.br_valid);
      end
      step(1'b0, 4'b0100, 16'h8000, 16'h0000);
      checks++;
      if (bus.br !== 1'b1 || bus.br_valid !== 1'b0) begin
         failures++;
         $display("FAIL en0_hold2 br=%b valid=%b expected br=1 valid=0", bus.br, bus.br_valid);
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 4'b0101, 16'h0005, 16'h0001);
      checks++;
      if (bus.br !== 1'b1 || bus.br_valid !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset br=%b valid=%b expected br=1 valid=1", bus.br, bus.br_valid);
      end
      // Enable still high with a true condition: that in-flight result must be dropped.
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.br !== 1'b0 || bus.br_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset br=%b valid=%b expected br=0 valid=0", bus.br, bus.br_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.br !== 1'b0 || bus.br_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_drop_inflight br=%b valid=%b expected br=0 valid=0", bus.br, bus.br_valid);
      end
      @(negedge clk);
      bus.en = 1'b0;
      rst = 1'b0;
      exp_br = 1'b0; exp_vld = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.br !== 1'b0 || bus.br_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle br=%b valid=%b expected br=0 valid=0", bus.br, bus.br_valid);
      end
   endtask

   task automatic test_random_sweep();
      logic [15:0] corners [4];
      logic [15:0] a, b;
      logic [3:0]  op;
      logic        e;
      corners[0] = 16'h0000; corners[1] = 16'h7FFF;
      corners[2] = 16'h8000; corners[3] = 16'hFFFF;
      for (int i = 0; i < 600; i++) begin
         op = (i < 64) ? 4'(i % 16) : 4'($urandom);
         a  = ($urandom_range(0, 1) != 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
         b  = ($urandom_range(0, 2) == 0) ? a :
              (($urandom_range(0, 1) != 0) ? corners[$urandom_range(0, 3)] : 16'($urandom));
         e  = ($urandom_range(0, 4) != 0);
         step(e, op, a, b);
         checks++;
         if (bus.br !== exp_br || bus.br_valid !== exp_vld) begin
            failures++;
            $display("FAIL random_%0d op=%h rd1=%h rd15=%h en=%b br=%b valid=%b expected br=%b valid=%b",
                     i, op, a, b, e, bus.br, bus.br_valid, exp_br, exp_vld);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bgt();
      test_blt();
      test_beq_bne();
      test_other_ops_and_hold();
      test_async_reset();
      test_random_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
